debug_inst_loader: RTL

Debug-unit side writer for the instruction memory inside FETCH. It takes a byte stream from the debug UART receiver and packs every four bytes into a 32-bit instruction, MSB first. Each instruction is written into FETCH through its debug write port (`i_Mem_WEn` / `i_Mem_Data` / `i_wr_addr`) at incrementing addresses from 0. Loading stops on the HALT instruction (opcode 6'b111111) or when memory overflows. While loading, the block holds FETCH in debug mode.

---
 rtl/debug_inst_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/debug_inst_loader.sv
// ---------------------------------------------------------------------------
// debug_inst_loader
//
// Purpose: packs a byte stream from the debug UART receiver into 32-bit
// instructions (MSB first) and writes them into the FETCH instruction memory
// through its debug write port, at addresses counting up from 0. A session
// ends when the HALT instruction has been written (o_done) or when the last
// memory word has been written without a HALT (o_error). While a session is
// active FETCH is held in debug mode.
//
// Ports:
//   i_clk, i_reset       clock; asynchronous active-high reset
//   i_start              one-cycle pulse: begin / restart a load session
//   i_rx_data/i_rx_valid received byte and its one-cycle strobe
//   o_debug_unit         FETCH debug-mode enable (high while loading)
//   o_Mem_WEn/o_Mem_REn  instruction-memory write strobe / read enable
//   o_Mem_Data,o_wr_addr instruction word and address to write
//   o_inst_count         words written in the current session
//   o_done, o_error      HALT written / memory full without HALT (levels)
// ---------------------------------------------------------------------------
`ifndef ADDRWIDTH
`define ADDRWIDTH 10
`endif
`ifndef N_ELEMENTS
`define N_ELEMENTS 1024
`endif

module debug_inst_loader #(
  parameter int         NB_INST     = 32,
  parameter int         NB_ADDR     = `ADDRWIDTH,
  parameter int         MEM_DEPTH   = `N_ELEMENTS,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_debug_unit,
  output logic               o_Mem_WEn,
  output logic               o_Mem_REn,
  output logic [NB_INST-1:0] o_Mem_Data,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_ADDR:0]   o_inst_count,
  output logic               o_done,
  output logic               o_error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);

  state_t               state_reg, state_next;
  // Only the first three bytes need holding; the fourth is merged directly
  // into the output word when it arrives.
  logic [NB_INST-9:0]   asm_reg, asm_next;
  logic [1:0]           cnt_reg, cnt_next;
  logic [NB_INST-1:0]   data_reg, data_next;
  logic [NB_ADDR-1:0]   addr_reg, addr_next;
  logic [NB_ADDR:0]     count_reg, count_next;
  logic                 done_reg, done_next;
  logic                 error_reg, error_next;
  logic                 debug_reg, debug_next;
  logic                 wen_reg, wen_next;
  logic                 restart;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= IDLE;
      asm_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      addr_reg  <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      debug_reg <= 1'b0;
      wen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      asm_reg   <= asm_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      debug_reg <= debug_next;
      wen_reg   <= wen_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    asm_next   = asm_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    done_next  = done_reg;
    error_next = error_reg;
    restart    = 1'b0;

    case (state_reg)
      IDLE, DONE, ERR: begin
        // Bytes arriving here are simply ignored.
        restart = i_start;
      end

      RECV: begin
        if (i_start) begin
          // Start beats a coincident byte; the partial word is dropped.
          restart = 1'b1;
        end else if (i_rx_valid) begin
          if (cnt_reg == 2'd3) begin
            data_next  = {asm_reg, i_rx_data};
            cnt_next   = 2'd0;
            state_next = WRITE;
          end else begin
            asm_next = {asm_reg[NB_INST-17:0], i_rx_data};
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end

      WRITE: begin
        // The write strobe is already high this cycle, so a restart here
        // cannot cancel the write; it only shapes the following cycle.
        count_next = count_reg + 1'b1;
        if (i_start) begin
          restart = 1'b1;
        end else if (data_reg[NB_INST-1:NB_INST-6] == HALT_OPCODE) begin
          done_next  = 1'b1;
          state_next = DONE;
        end else if (addr_reg == LAST_ADDR) begin
          error_next = 1'b1;
          state_next = ERR;
        end else begin
          addr_next  = addr_reg + 1'b1;
          state_next = RECV;
          // A byte landing in the write cycle is byte 0 of the next word,
          // which is what keeps one byte per cycle sustainable.
          if (i_rx_valid) begin
            asm_next = {asm_reg[NB_INST-17:0], i_rx_data};
            cnt_next = 2'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (restart) begin
      state_next = RECV;
      asm_next   = '0;
      cnt_next   = 2'd0;
      addr_next  = '0;
      count_next = '0;
      done_next  = 1'b0;
      error_next = 1'b0;
    end

    // Strobes are derived from the next state so they leave a register,
    // keeping every output free of combinational input paths.
    debug_next = (state_next == RECV) || (state_next == WRITE);
    wen_next   = (state_next == WRITE);
  end

  assign o_debug_unit = debug_reg;
  assign o_Mem_REn    = ~debug_reg;
  assign o_Mem_WEn    = wen_reg;
  assign o_Mem_Data   = data_reg;
  assign o_wr_addr    = addr_reg;
  assign o_inst_count = count_reg;
  assign o_done       = done_reg;
  assign o_error      = error_reg;

endmodule
